// File: rtl/box_fill_engine.sv
// box_fill_engine: rectangle-draw engine for the frame-buffer write path.
// A start pulse captures a box and a colour. The engine clips the box to the
// screen and then streams one pixel write per accepted cycle, in raster order.
// Mode 0 fills the whole box. Mode 1 writes only the outline.
//
// Ports:
//   clk, resetn          rising-edge clock; asynchronous active-low reset
//   start                one-cycle draw request, sampled only in IDLE
//   x_left/x_right       box columns, inclusive
//   y_top/y_bottom       box rows, inclusive
//   colour, mode         pixel colour; 0 = solid fill, 1 = outline only
//   wr_ready             write port accepts the current pixel this cycle
//   wr_en/x_out/y_out/col_out  pixel write request and payload
//   busy                 high while a box is being drawn
//   done/err             one-cycle completion pulse; err = box rejected
module box_fill_engine #(
   parameter int unsigned X_W   = 8,
   parameter int unsigned Y_W   = 7,
   parameter int unsigned COL_W = 3,
   parameter int unsigned X_MAX = 159,
   parameter int unsigned Y_MAX = 119
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [X_W-1:0]   x_left,
   input  logic [X_W-1:0]   x_right,
   input  logic [Y_W-1:0]   y_top,
   input  logic [Y_W-1:0]   y_bottom,
   input  logic [COL_W-1:0] colour,
   input  logic             mode,
   input  logic             wr_ready,
   output logic             wr_en,
   output logic [X_W-1:0]   x_out,
   output logic [Y_W-1:0]   y_out,
   output logic [COL_W-1:0] col_out,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
   localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

   state_t           state_q, state_d;
   logic [X_W-1:0]   x_q, x_d, xl_q, xl_d, r_q, r_d;
   logic [Y_W-1:0]   y_q, y_d, yt_q, yt_d, b_q, b_d;
   logic [COL_W-1:0] col_q, col_d;
   logic             mode_q, mode_d;
   logic             wr_en_q, wr_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [X_W-1:0]   clip_r_c;
   logic [Y_W-1:0]   clip_b_c;
   logic             mid_row_c;

   // Clip the right and bottom edges of the incoming box to the screen.
   assign clip_r_c = (x_right > X_LIM) ? X_LIM : x_right;
   assign clip_b_c = (y_bottom > Y_LIM) ? Y_LIM : y_bottom;

   // In outline mode, rows strictly between top and bottom skip their interior.
   assign mid_row_c = mode_q && (y_q > yt_q) && (y_q < b_q);

   // State and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         xl_q    <= '0;
         r_q     <= '0;
         yt_q    <= '0;
         b_q     <= '0;
         col_q   <= '0;
         mode_q  <= 1'b0;
         wr_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         xl_q    <= xl_d;
         r_q     <= r_d;
         yt_q    <= yt_d;
         b_q     <= b_d;
         col_q   <= col_d;
         mode_q  <= mode_d;
         wr_en_q <= wr_en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next-state, scan counters and the next value of each registered output.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      xl_d    = xl_q;
      r_d     = r_q;
      yt_d    = yt_q;
      b_d     = b_q;
      col_d   = col_q;
      mode_d  = mode_q;
      wr_en_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               xl_d   = x_left;
               yt_d   = y_top;
               r_d    = clip_r_c;
               b_d    = clip_b_c;
               col_d  = colour;
               mode_d = mode;
               if ((x_left > clip_r_c) || (y_top > clip_b_c)) begin
                  // Rejected box: report it without issuing any write.
                  state_d = DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  x_d     = x_left;
                  y_d     = y_top;
                  state_d = SCAN;
                  wr_en_d = 1'b1;
                  busy_d  = 1'b1;
               end
            end
         end

         SCAN: begin
            wr_en_d = 1'b1;
            busy_d  = 1'b1;
            if (wr_ready) begin
               if ((x_q == r_q) && (y_q == b_q)) begin
                  state_d = DONE;
                  wr_en_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else if (x_q == r_q) begin
                  x_d = xl_q;
                  y_d = y_q + Y_W'(1);
               end else if (mid_row_c && (x_q == xl_q)) begin
                  x_d = r_q;
               end else begin
                  x_d = x_q + X_W'(1);
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign wr_en   = wr_en_q;
   assign x_out   = x_q;
   assign y_out   = y_q;
   assign col_out = col_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_box_fill_engine.sv
// tb_box_fill_engine: directed table, hand sequences and random boxes for
// box_fill_engine, each checked against a pixel-list reference model.
module tb_box_fill_engine;

   localparam int unsigned X_W   = 8;
   localparam int unsigned Y_W   = 7;
   localparam int unsigned COL_W = 3;
   localparam int X_MAX = 159;
   localparam int Y_MAX = 119;

   logic             clk = 1'b0;
   logic             resetn = 1'b1;
   logic             start = 1'b0;
   logic [X_W-1:0]   x_left = '0;
   logic [X_W-1:0]   x_right = '0;
   logic [Y_W-1:0]   y_top = '0;
   logic [Y_W-1:0]   y_bottom = '0;
   logic [COL_W-1:0] colour = '0;
   logic             mode = 1'b0;
   logic             wr_ready = 1'b0;
   logic             wr_en;
   logic [X_W-1:0]   x_out;
   logic [Y_W-1:0]   y_out;
   logic [COL_W-1:0] col_out;
   logic             busy;
   logic             done;
   logic             err;

   box_fill_engine #(
      .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W), .X_MAX(159), .Y_MAX(119)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start),
      .x_left(x_left), .x_right(x_right), .y_top(y_top), .y_bottom(y_bottom),
      .colour(colour), .mode(mode), .wr_ready(wr_ready),
      .wr_en(wr_en), .x_out(x_out), .y_out(y_out), .col_out(col_out),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
   } pix_t;

   typedef struct {
      int xl; int xr; int yt; int yb; int col; bit md;
      int cnt; bit e; int done_cyc;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   pix_t exp_q[$];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: list every pixel the box should produce, in raster order.
   task automatic build_model(input int xl, input int xr, input int yt, input int yb,
                              input bit md, output int cnt, output bit e);
      int r;
      int b;
      r = (xr > X_MAX) ? X_MAX : xr;
      b = (yb > Y_MAX) ? Y_MAX : yb;
      exp_q.delete();
      e = (xl > r) || (yt > b);
      if (!e) begin
         for (int y = yt; y <= b; y++) begin
            for (int x = xl; x <= r; x++) begin
               if (!md || y == yt || y == b || x == xl || x == r) begin
                  exp_q.push_back('{x: x, y: y});
               end
            end
         end
      end
      cnt = exp_q.size();
   endtask

   // Issue one box and follow it to done. Cycle 1 is the cycle right after the
   // edge that samples start. Stalls: stall_first forced low cycles on the first
   // pixel, then wr_ready low with probability stall_pct percent.
   task automatic run_box(input int xl, input int xr, input int yt, input int yb,
                          input int col, input bit md,
                          input int stall_pct, input int stall_first,
                          output int nwr, output int done_cyc, output int stalls,
                          output int busy_cyc, output bit got_err);
      bit   prev_wait;
      int   px, py, pc;
      int   stall_left;
      pix_t p;
      @(negedge clk);
      x_left   = X_W'(xl);
      x_right  = X_W'(xr);
      y_top    = Y_W'(yt);
      y_bottom = Y_W'(yb);
      colour   = COL_W'(col);
      mode     = md;
      start    = 1'b1;
      wr_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      // Inputs are free to change once captured.
      x_left   = X_W'($urandom);
      x_right  = X_W'($urandom);
      y_top    = Y_W'($urandom);
      y_bottom = Y_W'($urandom);
      colour   = COL_W'($urandom);
      mode     = 1'($urandom);
      nwr = 0; stalls = 0; busy_cyc = 0; got_err = 1'b0; done_cyc = -1;
      prev_wait = 1'b0; px = 0; py = 0; pc = 0; stall_left = stall_first;
      for (int n = 1; n <= 2000; n++) begin
         if (n > 1) @(negedge clk);
         if (busy) busy_cyc++;
         if (done) begin
            done_cyc = n;
            got_err  = err;
            check("wr_en_at_done", int'(wr_en), 0);
            check("busy_at_done", int'(busy), 0);
            break;
         end
         check("err_without_done", int'(err), 0);
         if (wr_en) begin
            if (prev_wait) begin
               check("hold_x", int'(x_out), px);
               check("hold_y", int'(y_out), py);
               check("hold_col", int'(col_out), pc);
            end
            if (stall_left > 0) begin
               wr_ready = 1'b0;
               stall_left--;
            end else begin
               wr_ready = ($urandom_range(99) >= stall_pct);
            end
            if (wr_ready) begin
               if (exp_q.size() == 0) begin
                  check("extra_write", 1, 0);
               end else begin
                  p = exp_q.pop_front();
                  check("pix_x", int'(x_out), p.x);
                  check("pix_y", int'(y_out), p.y);
                  check("pix_col", int'(col_out), col);
               end
               nwr++;
            end else begin
               stalls++;
            end
            prev_wait = !wr_ready;
            px = int'(x_out); py = int'(y_out); pc = int'(col_out);
         end else begin
            check("wr_en_gap", int'(wr_en), 1);
         end
         @(posedge clk);
      end
      wr_ready = 1'b1;
      if (done_cyc < 0) check("timeout", 0, 1);
      check("pixels_missing", exp_q.size(), 0);
   endtask

   vec_t vecs[12];

   initial begin
      int nwr, dcyc, stalls, bcyc, mcnt;
      bit gerr, merr;
      pix_t p;

      vecs[0]  = '{2, 4, 1, 2, 5, 1'b0, 6, 1'b0, 7};         // solid fill
      vecs[1]  = '{0, 3, 0, 2, 2, 1'b1, 10, 1'b0, 11};       // outline
      vecs[2]  = '{158, 200, 119, 119, 6, 1'b0, 2, 1'b0, 3}; // right clip
      vecs[3]  = '{10, 5, 3, 4, 1, 1'b0, 0, 1'b1, 1};        // inverted x
      vecs[4]  = '{7, 7, 7, 7, 4, 1'b1, 1, 1'b0, 2};         // 1x1
      vecs[5]  = '{5, 5, 3, 9, 3, 1'b1, 7, 1'b0, 8};         // column, outline
      vecs[6]  = '{0, 9, 4, 4, 7, 1'b1, 10, 1'b0, 11};       // row, outline
      vecs[7]  = '{1, 2, 50, 40, 2, 1'b0, 0, 1'b1, 1};       // inverted y
      vecs[8]  = '{0, 0, 118, 127, 5, 1'b0, 2, 1'b0, 3};     // bottom clip
      vecs[9]  = '{10, 14, 20, 24, 6, 1'b1, 16, 1'b0, 17};   // 5x5 outline
      vecs[10] = '{3, 4, 125, 127, 1, 1'b0, 0, 1'b1, 1};     // top below screen
      vecs[11] = '{170, 180, 0, 1, 1, 1'b0, 0, 1'b1, 1};     // left past screen

      // Asynchronous reset clears every output immediately.
      #1 resetn = 1'b0;
      #1;
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      check("rst_x", int'(x_out), 0);
      check("rst_y", int'(y_out), 0);
      check("rst_col", int'(col_out), 0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      // Directed table with wr_ready held high.
      foreach (vecs[i]) begin
         build_model(vecs[i].xl, vecs[i].xr, vecs[i].yt, vecs[i].yb, vecs[i].md, mcnt, merr);
         run_box(vecs[i].xl, vecs[i].xr, vecs[i].yt, vecs[i].yb, vecs[i].col, vecs[i].md,
                 0, 0, nwr, dcyc, stalls, bcyc, gerr);
         check($sformatf("vec%0d_writes", i), nwr, vecs[i].cnt);
         check($sformatf("vec%0d_err", i), int'(gerr), int'(vecs[i].e));
         check($sformatf("vec%0d_done_cycle", i), dcyc, vecs[i].done_cyc);
         check($sformatf("vec%0d_busy_cycles", i), bcyc, vecs[i].cnt);
      end

      // Back-pressure: first pixel stalled for three cycles.
      build_model(3, 4, 5, 5, 1'b0, mcnt, merr);
      run_box(3, 4, 5, 5, 2, 1'b0, 0, 3, nwr, dcyc, stalls, bcyc, gerr);
      check("bp_writes", nwr, 2);
      check("bp_done_cycle", dcyc, 6);
      check("bp_stalls", stalls, 3);
      check("bp_err", int'(gerr), 0);

      // Start during SCAN is ignored; reset mid-box aborts the draw.
      build_model(0, 9, 0, 3, 1'b0, mcnt, merr);
      @(negedge clk);
      x_left = 8'd0; x_right = 8'd9; y_top = 7'd0; y_bottom = 7'd3;
      colour = 3'd3; mode = 1'b0; start = 1'b1; wr_ready = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         start = (i == 3);
         if (i == 3) begin
            x_left = 8'd50; x_right = 8'd60; y_top = 7'd30; y_bottom = 7'd31;
            colour = 3'd6; mode = 1'b1;
         end
         check("sb_wr_en", int'(wr_en), 1);
         p = exp_q.pop_front();
         check("sb_x", int'(x_out), p.x);
         check("sb_y", int'(y_out), p.y);
         check("sb_col", int'(col_out), 3);
      end
      @(negedge clk);
      start = 1'b0;
      check("sb_still_first_box_x", int'(x_out), 8);
      #2 resetn = 1'b0;
      #1;
      check("midrst_wr_en", int'(wr_en), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_x", int'(x_out), 0);
      @(negedge clk);
      check("midrst_no_done", int'(done), 0);
      resetn = 1'b1;
      build_model(5, 7, 8, 9, 1'b0, mcnt, merr);
      run_box(5, 7, 8, 9, 4, 1'b0, 0, 0, nwr, dcyc, stalls, bcyc, gerr);
      check("post_rst_writes", nwr, 6);
      check("post_rst_done_cycle", dcyc, 7);

      // Random boxes with random back-pressure.
      for (int t = 0; t < 40; t++) begin
         int xl, xr, yt, yb, col;
         bit md;
         xl = $urandom_range(0, 170);
         xr = xl + $urandom_range(0, 12) - 2;
         if (xr < 0) xr = 0;
         if (xr > 255) xr = 255;
         yt = $urandom_range(0, 125);
         yb = yt + $urandom_range(0, 8) - 1;
         if (yb < 0) yb = 0;
         if (yb > 127) yb = 127;
         col = $urandom_range(0, 7);
         md  = 1'($urandom);
         build_model(xl, xr, yt, yb, md, mcnt, merr);
         run_box(xl, xr, yt, yb, col, md, 30, 0, nwr, dcyc, stalls, bcyc, gerr);
         check("rnd_writes", nwr, mcnt);
         check("rnd_err", int'(gerr), int'(merr));
         check("rnd_done_cycle", dcyc, mcnt + stalls + 1);
         check("rnd_busy_cycles", bcyc, mcnt + stalls);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/box_fill_engine.md
Name: box_fill_engine

Overview:
- Parametrised rectangle-draw engine for the frame-buffer path. Replaces the fixed 3-bit, black-only box cleaner.
- On a start pulse it latches a box and a colour, clips the box to the screen, and streams one pixel write per accepted cycle to the memory/VGA write port.
- Supports solid-fill and outline-only modes, write back-pressure, and error reporting for inverted boxes.
- Sits between the star-finding control FSM and the frame-buffer write arbiter.

Parameters:
- X_W, 8, width of all x coordinates.
- Y_W, 7, width of all y coordinates.
- COL_W, 3, pixel colour width.
- X_MAX, 159, largest legal x; right edge is clipped to this.
- Y_MAX, 119, largest legal y; bottom edge is clipped to this.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- x_left  in  X_W  box left column, inclusive.
- x_right  in  X_W  box right column, inclusive.
- y_top  in  Y_W  box top row, inclusive.
- y_bottom  in  Y_W  box bottom row, inclusive.
- colour  in  COL_W  fill colour.
- mode  in  1  0 = solid fill, 1 = outline only.
- wr_ready  in  1  write port accepts the current pixel this cycle.
- wr_en  out  1  pixel write valid.
- x_out  out  X_W  pixel column.
- y_out  out  Y_W  pixel row.
- col_out  out  COL_W  pixel colour.
- busy  out  1  high while a box is being drawn.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done; high = box rejected, nothing written.

Behaviour:
- One clock domain, clk. resetn is asynchronous and active-low. Assertion forces all state and outputs to 0 immediately: state = IDLE, wr_en = 0, busy = 0, done = 0, err = 0, x_out = 0, y_out = 0, col_out = 0.
- States are IDLE, SCAN and DONE.
- IDLE, start = 1 at edge k:
  - Latch colour, mode and the clipped box: R = min(x_right, X_MAX), B = min(y_bottom, Y_MAX).
  - x_left and y_top are used as given.
  - If x_left > R or y_top > B: err_reg = 1 and the next state is DONE. No write is ever issued.
  - Otherwise load x_out = x_left and y_out = y_top, and the next state is SCAN.
  - Latency: wr_en is high in the cycle immediately after edge k.
- SCAN:
  - wr_en = 1, busy = 1, col_out = latched colour.
  - A pixel is consumed only at an edge where wr_en and wr_ready are both 1. If wr_ready = 0, x_out, y_out and col_out hold stable.
  - On accept at x_out == R, y_out == B: next state is DONE.
  - On accept at x_out == R otherwise: x_out = x_left, y_out = y_out + 1.
  - On any other accept, fill mode: x_out = x_out + 1.
  - On any other accept, outline mode: if y_out is strictly between y_top and B and x_out == x_left, x_out jumps to R. Otherwise x_out = x_out + 1.
  - Writes are raster order, left to right, then top to bottom.
- DONE: for exactly one cycle, done = 1, err = err_reg, busy = 0, wr_en = 0. Then go to IDLE and clear err_reg. Output err is 0 in every other cycle.
- Pixel counts with W = R - x_left + 1 and H = B - y_top + 1:
  - Fill writes W*H pixels.
  - Outline writes W*H when W ≤ 2 or H ≤ 2, else 2W + 2(H-2).
  - With wr_ready held high, done occurs exactly count + 1 cycles after start is sampled.
- Degenerate boxes: a 1×1 box issues exactly one write. A single row or single column is written in full in either mode.
- start is ignored while in SCAN or DONE; the latched box is unaffected.
- Box and colour inputs may change freely after capture.
- Arithmetic: counters are X_W and Y_W wide. Clipping guarantees they never wrap past R or B.
- Reset mid-SCAN aborts the draw: no done pulse, and wr_en drops asynchronously.

Test Plan:
- Solid fill:
  - Stimulus: fill box x 2..4, y 1..2, colour 5, wr_ready = 1.
  - Response: writes (2,1),(3,1),(4,1),(2,2),(3,2),(4,2), all col_out = 5. done = 1, err = 0 in the 7th cycle after start. busy high for exactly 6 cycles.
- Outline mode:
  - Stimulus: x 0..3, y 0..2, mode = 1.
  - Response: 10 writes. Row 1 writes only (0,1),(3,1). Pixels (1,1),(2,1) are never written.
- Back-pressure:
  - Stimulus: 2×1 box; wr_ready low for 3 cycles on the first pixel, then high.
  - Response: (x_left, y_top) held stable for 4 cycles, 2 writes total, done 6 cycles after start.
- Clipping:
  - Stimulus: x 158..200, y 119..119 with the default parameters.
  - Response: writes only (158,119),(159,119), then done with err = 0.
- Inverted box:
  - Stimulus: x_left = 10, x_right = 5.
  - Response: zero writes. done = 1 and err = 1 in the cycle after start. busy never high.
- Start-while-busy and reset mid-draw:
  - Stimulus: start pulse during SCAN, then resetn low mid-box.
  - Response: the second start has no effect. On reset, wr_en, busy and done are 0 immediately. Next start after release draws normally from IDLE.
